uart_loader: RTL

UART_LOADER -- requirements
Module: uart_loader

---
 rtl/uart_loader.sv | 266 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_loader.sv
// rtl/uart_loader.sv - UART byte receiver feeding a packet FSM that issues single 32-bit bus writes.
// Optional trailing XOR check byte enabled by macro UART_LOADER_CHKSUM_EN.
module uart_loader #(
  parameter int BAUD_DIV = 434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  output logic        busy_o,
  output logic [15:0] pkt_cnt_o,
  output logic [7:0]  err_cnt_o
);

  localparam logic [15:0] BIT_LAST  = 16'(BAUD_DIV - 1);
  localparam logic [15:0] HALF_LAST = 16'(BAUD_DIV / 2 - 1);
  localparam logic [7:0]  SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

`ifdef UART_LOADER_CHKSUM_EN
  typedef enum logic [2:0] {P_SYNC, P_ADDR, P_DATA, P_CHK, P_WRITE} pkt_state_e;
`else
  typedef enum logic [2:0] {P_SYNC, P_ADDR, P_DATA, P_WRITE} pkt_state_e;
`endif

  rx_state_e  rx_state_q, rx_state_d;
  pkt_state_e pkt_state_q, pkt_state_d;

  logic        rx_meta_q, rx_meta_d;
  logic        rx_sync_q, rx_sync_d;
  logic        rx_prev_q, rx_prev_d;
  logic [15:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        buf_valid_q, buf_valid_d;
  logic [7:0]  buf_data_q, buf_data_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [15:0] pkt_cnt_q, pkt_cnt_d;
  logic [7:0]  err_cnt_q, err_cnt_d;
`ifdef UART_LOADER_CHKSUM_EN
  logic [7:0]  chk_q, chk_d;
`endif

  logic       byte_done;
  logic       frame_err;
  logic       overrun;
  logic       consume;
  logic       rx_err;
  logic       pkt_err;
  logic       wr_done;
  logic [1:0] err_inc;
  logic [8:0] err_sum;

  // Receiver: start edge, half-bit alignment, then one sample per bit period
  always_comb begin
    rx_meta_d  = rx_i;
    rx_sync_d  = rx_meta_q;
    rx_prev_d  = rx_sync_q;
    rx_state_d = rx_state_q;
    baud_cnt_d = baud_cnt_q + 16'd1;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    byte_done  = 1'b0;
    frame_err  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        baud_cnt_d = 16'd0;
        if (rx_prev_q && !rx_sync_q) begin
          rx_state_d = RX_START;
        end
      end
      RX_START: begin
        if (baud_cnt_q == HALF_LAST) begin
          baud_cnt_d = 16'd0;
          bit_cnt_d  = 3'd0;
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (baud_cnt_q == BIT_LAST) begin
          baud_cnt_d = 16'd0;
          shift_d    = {rx_sync_q, shift_q[7:1]};
          bit_cnt_d  = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            rx_state_d = RX_STOP;
          end
        end
      end
      RX_STOP: begin
        if (baud_cnt_q == BIT_LAST) begin
          baud_cnt_d = 16'd0;
          rx_state_d = RX_IDLE;
          byte_done  = rx_sync_q;
          frame_err  = !rx_sync_q;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // A byte landing on an unconsumed buffer is an overrun and empties the buffer
  assign consume = buf_valid_q && (pkt_state_q != P_WRITE);
  assign overrun = byte_done && buf_valid_q && !consume;
  assign rx_err  = frame_err || overrun;

  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_data_d  = buf_data_q;
    if (consume) begin
      buf_valid_d = 1'b0;
    end
    if (byte_done) begin
      if (overrun) begin
        buf_valid_d = 1'b0;
      end else begin
        buf_valid_d = 1'b1;
        buf_data_d  = shift_q;
      end
    end
  end

  always_comb begin
    pkt_state_d = pkt_state_q;
    byte_cnt_d  = byte_cnt_q;
    addr_d      = addr_q;
    data_d      = data_q;
`ifdef UART_LOADER_CHKSUM_EN
    chk_d       = chk_q;
`endif
    pkt_err     = 1'b0;
    wr_done     = 1'b0;
    case (pkt_state_q)
      P_SYNC: begin
        if (consume && (buf_data_q == SYNC_BYTE)) begin
          pkt_state_d = P_ADDR;
          byte_cnt_d  = 2'd0;
`ifdef UART_LOADER_CHKSUM_EN
          chk_d       = 8'd0;
`endif
        end
      end
      P_ADDR: begin
        if (consume) begin
          addr_d     = {buf_data_q, addr_q[31:8]};
          byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef UART_LOADER_CHKSUM_EN
          chk_d      = chk_q ^ buf_data_q;
`endif
          if (byte_cnt_q == 2'd3) begin
            pkt_state_d = P_DATA;
          end
        end
      end
      P_DATA: begin
        if (consume) begin
          data_d     = {buf_data_q, data_q[31:8]};
          byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef UART_LOADER_CHKSUM_EN
          chk_d      = chk_q ^ buf_data_q;
          if (byte_cnt_q == 2'd3) begin
            pkt_state_d = P_CHK;
          end
`else
          if (byte_cnt_q == 2'd3) begin
            if (addr_q[1:0] != 2'b00) begin
              pkt_err     = 1'b1;
              pkt_state_d = P_SYNC;
            end else begin
              pkt_state_d = P_WRITE;
            end
          end
`endif
        end
      end
`ifdef UART_LOADER_CHKSUM_EN
      P_CHK: begin
        if (consume) begin
          if ((buf_data_q != chk_q) || (addr_q[1:0] != 2'b00)) begin
            pkt_err     = 1'b1;
            pkt_state_d = P_SYNC;
          end else begin
            pkt_state_d = P_WRITE;
          end
        end
      end
`endif
      P_WRITE: begin
        if (mem_gnt_i) begin
          wr_done     = 1'b1;
          pkt_state_d = P_SYNC;
        end
      end
      default: pkt_state_d = P_SYNC;
    endcase
    if (rx_err) begin
      pkt_state_d = P_SYNC;
    end
  end

  // Receiver and packet errors in the same cycle each count
  assign err_inc = {1'b0, rx_err} + {1'b0, pkt_err};
  assign err_sum = {1'b0, err_cnt_q} + {7'd0, err_inc};

  always_comb begin
    pkt_cnt_d = pkt_cnt_q + {15'd0, wr_done};
    err_cnt_d = err_sum[8] ? 8'hFF : err_sum[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      rx_prev_q   <= 1'b1;
      rx_state_q  <= RX_IDLE;
      baud_cnt_q  <= 16'd0;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'd0;
      buf_valid_q <= 1'b0;
      buf_data_q  <= 8'd0;
      pkt_state_q <= P_SYNC;
      byte_cnt_q  <= 2'd0;
      addr_q      <= 32'd0;
      data_q      <= 32'd0;
      pkt_cnt_q   <= 16'd0;
      err_cnt_q   <= 8'd0;
`ifdef UART_LOADER_CHKSUM_EN
      chk_q       <= 8'd0;
`endif
    end else begin
      rx_meta_q   <= rx_meta_d;
      rx_sync_q   <= rx_sync_d;
      rx_prev_q   <= rx_prev_d;
      rx_state_q  <= rx_state_d;
      baud_cnt_q  <= baud_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      buf_valid_q <= buf_valid_d;
      buf_data_q  <= buf_data_d;
      pkt_state_q <= pkt_state_d;
      byte_cnt_q  <= byte_cnt_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      pkt_cnt_q   <= pkt_cnt_d;
      err_cnt_q   <= err_cnt_d;
`ifdef UART_LOADER_CHKSUM_EN
      chk_q       <= chk_d;
`endif
    end
  end

  assign mem_req_o   = (pkt_state_q == P_WRITE);
  assign mem_we_o    = mem_req_o;
  assign mem_addr_o  = mem_req_o ? addr_q : 32'd0;
  assign mem_wdata_o = mem_req_o ? data_q : 32'd0;
  assign busy_o      = (pkt_state_q != P_SYNC);
  assign pkt_cnt_o   = pkt_cnt_q;
  assign err_cnt_o   = err_cnt_q;

endmodule
